// File: rtl/daq_pkg.sv
// Shared types and constants for the AD7606 acquisition path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package daq_pkg;

   // Reader FSM states
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_L,
      ST_RD_H,
      ST_STREAM
   } state_t;

   localparam int         NCH         = 8;
   localparam int         FRAME_BYTES = 18;
   localparam logic [7:0] HDR_DEFAULT = 8'hA5;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Latency: 2 clk_i cycles from input change to dout.
// Backpressure: none.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic din,
   output logic dout
);

   logic meta;

   // Two-stage capture; both stages reset to the idle level of the input
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         meta <= RST_VAL;
         dout <= RST_VAL;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/ad7606_reader.sv
// Reads 8 AD7606 channels after each BUSY fall and streams an 18-byte frame to a byte FIFO.
// Latency: cs_no falls on the 3rd clk_i edge after BUSY is first sampled low.
// Backpressure: wrfull_i stalls the byte stream in place; BUSY falls outside IDLE count as overruns.
module ad7606_reader #(
   parameter int         RD_LOW  = 2,
   parameter int         RD_HIGH = 2,
   parameter logic [7:0] HDR     = daq_pkg::HDR_DEFAULT
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        en_i,
   input  logic        busy_i,
   input  logic        frstdata_i,
   input  logic [15:0] db_i,
   input  logic        wrfull_i,
   input  logic        clr_i,
   output logic        cs_no,
   output logic        rd_no,
   output logic        wrreq_o,
   output logic [7:0]  data_o,
   output logic [7:0]  seq_o,
   output logic [7:0]  ovr_cnt_o,
   output logic        frame_err_o
);

   import daq_pkg::*;

   localparam logic [3:0] RD_L_LAST = 4'(RD_LOW - 1);
   localparam logic [3:0] RD_H_LAST = 4'(RD_HIGH - 1);
   localparam logic [4:0] LAST_BYTE = 5'(FRAME_BYTES - 1);
   localparam logic [2:0] LAST_CH   = 3'(NCH - 1);

   state_t      state, state_nxt;
   logic [2:0]  ch;
   logic [3:0]  cnt;
   logic [4:0]  byte_idx;
   logic [3:0]  w_off;
   logic [15:0] word_buf [NCH];
   logic        busy_s, busy_d, busy_fall;
   logic [7:0]  seq, ovr_cnt, cur_byte;
   logic        frame_err;
   logic        start, capture, frame_bad, frame_done;

   sync2 #(.RST_VAL(1'b1)) u_busy_sync (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .din      (busy_i),
      .dout     (busy_s)
   );

   // Delay the synchronized BUSY by one cycle to find its falling edge
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) busy_d <= 1'b1;
      else           busy_d <= busy_s;
   end

   assign busy_fall = busy_d & ~busy_s;

   // Select the frame byte: header, sequence, then each word high byte first
   always_comb begin
      w_off    = 4'(byte_idx - 5'd2);
      cur_byte = 8'h00;
      if (byte_idx == 5'd0)      cur_byte = HDR;
      else if (byte_idx == 5'd1) cur_byte = seq;
      else if (w_off[0])         cur_byte = word_buf[w_off[3:1]][7:0];
      else                       cur_byte = word_buf[w_off[3:1]][15:8];
   end

   // Next-state and strobe decode; wrreq_o follows wrfull_i in the same cycle
   always_comb begin
      state_nxt  = state;
      cs_no      = 1'b1;
      rd_no      = 1'b1;
      wrreq_o    = 1'b0;
      data_o     = 8'h00;
      start      = 1'b0;
      capture    = 1'b0;
      frame_bad  = 1'b0;
      frame_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (busy_fall && en_i) begin
               start     = 1'b1;
               state_nxt = ST_RD_L;
            end
         end
         ST_RD_L: begin
            cs_no = 1'b0;
            rd_no = 1'b0;
            if (cnt == RD_L_LAST) begin
               if (ch == 3'd0 && !frstdata_i) begin
                  frame_bad = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  capture   = 1'b1;
                  state_nxt = (ch == LAST_CH) ? ST_STREAM : ST_RD_H;
               end
            end
         end
         ST_RD_H: begin
            cs_no = 1'b0;
            if (cnt == RD_H_LAST) state_nxt = ST_RD_L;
         end
         ST_STREAM: begin
            wrreq_o = ~wrfull_i;
            data_o  = cur_byte;
            if (!wrfull_i && byte_idx == LAST_BYTE) begin
               frame_done = 1'b1;
               state_nxt  = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state <= ST_IDLE;
      else           state <= state_nxt;
   end

   // Phase counter restarts on every state change; channel and byte indices
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt      <= 4'd0;
         ch       <= 3'd0;
         byte_idx <= 5'd0;
      end else begin
         cnt <= (state_nxt != state) ? 4'd0 : cnt + 4'd1;
         if (start)
            ch <= 3'd0;
         else if (state == ST_RD_H && state_nxt == ST_RD_L)
            ch <= ch + 3'd1;
         if (state != ST_STREAM || frame_done)
            byte_idx <= 5'd0;
         else if (wrreq_o)
            byte_idx <= byte_idx + 5'd1;
      end
   end

   // Capture the data bus at the end of each read-low phase
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < NCH; i++) word_buf[i] <= 16'h0000;
      end else if (capture) begin
         word_buf[ch] <= db_i;
      end
   end

   // Sequence number, saturating overrun count and sticky alignment error
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         seq       <= 8'h00;
         ovr_cnt   <= 8'h00;
         frame_err <= 1'b0;
      end else begin
         if (frame_done) seq <= seq + 8'd1;
         if (busy_fall && state != ST_IDLE) begin
            if (ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
         end else if (clr_i) begin
            ovr_cnt <= 8'h00;
         end
         if (frame_bad)  frame_err <= 1'b1;
         else if (clr_i) frame_err <= 1'b0;
      end
   end

   assign seq_o       = seq;
   assign ovr_cnt_o   = ovr_cnt;
   assign frame_err_o = frame_err;

endmodule

// File: doc/ad7606_reader.md
AD7606_READER -- requirements
Module: ad7606_reader

Interface
REQ-001 Parameter RD_LOW, default 2, meaning: rd_no low-phase length in clk_i cycles (legal range 1..15).
REQ-002 Parameter RD_HIGH, default 2, meaning: rd_no high-phase length between channel reads, in clk_i cycles (legal range 1..15).
REQ-003 Parameter HDR, default 8'hA5, meaning: frame header byte.
REQ-004 clk_i  input  1  sole clock; all logic on its rising edge.
REQ-005 reset_ni  input  1  asynchronous, active-low reset.
REQ-006 en_i  input  1  permits new conversion frames to start.
REQ-007 busy_i  input  1  AD7606 BUSY, asynchronous to clk_i.
REQ-008 frstdata_i  input  1  AD7606 FRSTDATA.
REQ-009 db_i  input  16  AD7606 parallel data bus.
REQ-010 wrfull_i  input  1  downstream 8-bit FIFO full flag.
REQ-011 clr_i  input  1  one-cycle pulse that clears the sticky flags and ovr_cnt_o.
REQ-012 cs_no  output  1  AD7606 chip select, active low.
REQ-013 rd_no  output  1  AD7606 read strobe, active low.
REQ-014 wrreq_o  output  1  FIFO write request.
REQ-015 data_o  output  8  FIFO write data.
REQ-016 seq_o  output  8  sequence number of the next frame to be streamed.
REQ-017 ovr_cnt_o  output  8  count of skipped frames, saturating.
REQ-018 frame_err_o  output  1  sticky flag: FRSTDATA misalignment was detected.

Function
REQ-019 busy_i SHALL pass through a 2-flop synchronizer; a falling edge SHALL be detected on the synchronized signal.
REQ-020 FSM states SHALL be IDLE, RD_L, RD_H, STREAM.
REQ-021 IDLE: when a busy falling edge is detected and en_i=1, the FSM SHALL go to RD_L with ch=0; cs_no SHALL go low on the 3rd rising edge after busy_i is first sampled low.
REQ-022 RD_L: cs_no=0 and rd_no=0 for RD_LOW cycles; db_i SHALL be captured into word buffer[ch] on the last RD_L cycle.
REQ-023 RD_H: cs_no=0 and rd_no=1 for RD_HIGH cycles, then the FSM SHALL go to RD_L with ch+1; after ch=7 completes RD_L, the FSM SHALL go to STREAM with cs_no=1.
REQ-024 On ch=0 capture, if frstdata_i=0, frame_err_o SHALL be set, the frame SHALL be discarded, and the FSM SHALL return to IDLE with cs_no=1 and rd_no=1.
REQ-025 A frame SHALL be 18 bytes in this order: HDR, seq_o, then buffer[0..7], each word MSB first.
REQ-026 STREAM: wrreq_o SHALL equal NOT wrfull_i (combinational, same cycle), with data_o set to the current byte; the byte index SHALL advance only on a cycle where wrreq_o=1.
REQ-027 After byte 17 is written, seq_o SHALL increment modulo 256 (255 wraps to 0) and the FSM SHALL go to IDLE.
REQ-028 A busy falling edge detected in any state other than IDLE SHALL NOT start a frame; ovr_cnt_o SHALL increment and saturate at 255.
REQ-029 en_i=0 SHALL block only new frame starts; a frame already in progress SHALL complete.
REQ-030 clr_i SHALL clear frame_err_o and ovr_cnt_o; a set or increment in the same cycle SHALL take priority over the clear.
REQ-031 In IDLE, wrreq_o=0 and data_o=8'h00.

Reset
REQ-032 While reset_ni=0 the block SHALL hold: state=IDLE, cs_no=1, rd_no=1, wrreq_o=0, data_o=0, seq_o=0, ovr_cnt_o=0, frame_err_o=0, synchronizer flops=1, word buffer=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, writing no further bytes.

Structure
REQ-034 Shared package daq_pkg SHALL hold the FSM state typedef, NCH=8, FRAME_BYTES=18, and the default HDR.
REQ-035 The synchronizer SHALL be a sub-module named sync2 (2-flop, reset value parameterised).

Verification
REQ-036 Basic frame: busy pulse; ADC model drives channel n = 16'h1100+n with FRSTDATA on ch0; wrfull_i=0 -> bytes A5,00,11,00,11,01,...,11,07; seq_o=1 afterwards.
REQ-037 Backpressure: wrfull_i=1 for 5 cycles at byte 4 -> wrreq_o=0 for those cycles; byte sequence is identical with no loss or duplicate.
REQ-038 Overrun: second busy fall during STREAM -> ovr_cnt_o=1, one frame output; 300 overruns -> ovr_cnt_o=255.
REQ-039 FRSTDATA fault: frstdata_i=0 on ch0 -> frame_err_o=1, zero bytes written, seq_o unchanged; then clr_i -> frame_err_o=0.
REQ-040 Reset mid-frame at RD_L of ch=3 -> cs_no=1 and rd_no=1 immediately; next busy fall yields a complete frame with seq byte 00.
REQ-041 Wrap and timing: 256 frames -> seq byte goes 255 then 0; RD_LOW=3, RD_HIGH=1 -> rd_no low exactly 3 cycles per channel, 8 pulses per frame.
